// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared state encodings, access-type codes and default address map for the memory bridge.
package mem_bridge_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {MT_WORD = 2'b00, MT_HALF = 2'b01, MT_BYTE = 2'b11} mem_type_t;
    localparam int          TIMEOUT_DEF   = 16;
    localparam logic [31:0] DM_LIMIT_DEF  = 32'h0000_3000;
    localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7F10;
    localparam logic [31:0] DEV_SPAN      = 32'h0000_000B;
    function automatic logic in_slot(input logic [31:0] a, input logic [31:0] base);
        return (a >= base) && (a <= base + DEV_SPAN);
    endfunction
endpackage

// File: rtl/mem_bridge_ctrl_if.sv
// mem_bridge_ctrl_if: CPU, peripheral and interrupt signals of the memory bridge.
interface mem_bridge_ctrl_if;
    logic        MemReadM, MemWriteM;
    logic [1:0]  MemTypeM;
    logic [31:0] AddrM, WriteDataM;
    logic        DMWE;
    logic [3:0]  DevAddr;
    logic [31:0] DevWD;
    logic        DevReq0, DevReq1, DevWE;
    logic [31:0] DevRD0, DevRD1;
    logic        DevAck0, DevAck1, DevIRQ0, DevIRQ1;
    logic        StallM, MemorySelectM, BusErrM;
    logic [31:0] CPURDM;
    logic [5:0]  HWInt;
    modport master (
        input  MemReadM, MemWriteM, MemTypeM, AddrM, WriteDataM,
        input  DevRD0, DevRD1, DevAck0, DevAck1, DevIRQ0, DevIRQ1,
        output DMWE, DevAddr, DevWD, DevReq0, DevReq1, DevWE,
        output StallM, MemorySelectM, CPURDM, BusErrM, HWInt
    );
    modport slave (
        output MemReadM, MemWriteM, MemTypeM, AddrM, WriteDataM,
        output DevRD0, DevRD1, DevAck0, DevAck1, DevIRQ0, DevIRQ1,
        input  DMWE, DevAddr, DevWD, DevReq0, DevReq1, DevWE,
        input  StallM, MemorySelectM, CPURDM, BusErrM, HWInt
    );
endinterface

// File: rtl/mem_bridge_ctrl_irq_sync.sv
// irq_sync: two-flop synchroniser for one asynchronous interrupt level.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], d};
    assign q = sync_q[1];
endmodule

// File: rtl/mem_bridge_ctrl.sv
// mem_bridge_ctrl: decodes M-stage accesses and sequences the variable-latency
// peripheral handshake, stalling the pipeline and flagging illegal or timed-out accesses.
module mem_bridge_ctrl
    import mem_bridge_pkg::*;
#(
    parameter int          TIMEOUT   = TIMEOUT_DEF,
    parameter logic [31:0] DM_LIMIT  = DM_LIMIT_DEF,
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF
) (
    input logic               clk,
    input logic               reset,
    mem_bridge_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    state_t      state_q, state_d;
    logic [1:0]  req_q, req_d;
    logic        we_q, we_d, err_q, err_d;
    logic [31:0] wd_q, wd_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic access, dm_hit, dev0, dev1, aligned, dev_ok, illegal;
    logic idle, wt, done, ack, tmo, irq0, irq1;
    assign access  = bus.MemReadM | bus.MemWriteM;
    assign dm_hit  = bus.AddrM < DM_LIMIT;
    assign dev0    = in_slot(bus.AddrM, DEV0_BASE);
    assign dev1    = in_slot(bus.AddrM, DEV1_BASE);
    assign aligned = (bus.MemTypeM == MT_WORD) && (bus.AddrM[1:0] == 2'b00);
    assign dev_ok  = access && (dev0 || dev1) && aligned;
    assign illegal = access && !dm_hit && !dev_ok;
    assign idle    = state_q == IDLE;
    assign wt      = state_q == WAIT;
    assign done    = state_q == DONE;
    // Only the slot that was actually requested can complete the transfer.
    assign ack     = (req_q[0] && bus.DevAck0) || (req_q[1] && bus.DevAck1);
    assign tmo     = cnt_q == CW'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        cnt_d   = '0;
        if (idle && dev_ok) begin
            state_d = WAIT;
            req_d   = {dev1, dev0};
            we_d    = bus.MemWriteM;
            wd_d    = bus.WriteDataM;
        end else if (wt) begin
            cnt_d = cnt_q + CW'(1);
            if (ack) begin
                state_d = DONE;
                req_d   = 2'b00;
                rd_d    = we_q ? rd_q : (req_q[1] ? bus.DevRD1 : bus.DevRD0);
            end else if (tmo) begin
                state_d = DONE;
                req_d   = 2'b00;
                rd_d    = '0;
                err_d   = 1'b1;
            end
        end else if (done) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 2'b00;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    // Combinational outputs are gated by reset so they drop without a clock edge.
    assign bus.DMWE          = !reset && idle && dm_hit && bus.MemWriteM;
    assign bus.StallM        = !reset && (wt || (idle && dev_ok));
    assign bus.MemorySelectM = !reset && (!idle || dev_ok);
    assign bus.BusErrM       = !reset && ((idle && illegal) || (done && err_q));
    assign bus.DevAddr       = bus.AddrM[3:0];
    assign bus.DevWD         = wd_q;
    assign bus.DevReq0       = req_q[0];
    assign bus.DevReq1       = req_q[1];
    assign bus.DevWE         = we_q;
    assign bus.CPURDM        = rd_q;
    irq_sync u_irq0 (.clk(clk), .rst(reset), .d(bus.DevIRQ0), .q(irq0));
    irq_sync u_irq1 (.clk(clk), .rst(reset), .d(bus.DevIRQ1), .q(irq1));
    assign bus.HWInt = {4'b0000, irq1, irq0};
endmodule

// File: tb/tb_mem_bridge_ctrl.sv
// tb_mem_bridge_ctrl: directed decode vectors plus hand-written handshake,
// timeout, interrupt and reset sequences for mem_bridge_ctrl.
module tb_mem_bridge_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    mem_bridge_ctrl_if bus ();
    mem_bridge_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        rd, wr;
        logic [1:0]  mt;
        logic [31:0] addr;
        logic        dmwe, err;
    } vec_t;
    vec_t tbl [12];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic rd, input logic wr, input logic [1:0] mt,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.MemReadM   = rd;
        bus.MemWriteM  = wr;
        bus.MemTypeM   = mt;
        bus.AddrM      = addr;
        bus.WriteDataM = wd;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int sc, rc, w, pre_err;
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0010, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0010, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'b11, 32'h0000_2FFF, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'b00, 32'h0000_3000, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 32'h0000_5000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 2'b11, 32'h0000_7F00, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 2'b01, 32'h0000_7F04, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 2'b00, 32'h0000_7F02, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, 32'h0000_7F0C, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'b00, 32'h0000_7F1C, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'b00, 32'h0000_5000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'b00, 32'h0000_7EFC, 1'b0, 1'b1};
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        bus.DevRD0 = 32'h0; bus.DevRD1 = 32'h0;
        bus.DevAck0 = 0; bus.DevAck1 = 0; bus.DevIRQ0 = 0; bus.DevIRQ1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst StallM", 32'(bus.StallM), 0);
        chk("rst DMWE", 32'(bus.DMWE), 0);
        chk("rst BusErrM", 32'(bus.BusErrM), 0);
        chk("rst DevReq", 32'({bus.DevReq1, bus.DevReq0, bus.DevWE}), 0);
        chk("rst DevWD", bus.DevWD, 0);
        chk("rst CPURDM", bus.CPURDM, 0);
        chk("rst HWInt", 32'(bus.HWInt), 0);
        reset = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].mt, tbl[i].addr, 32'h5555_AAAA);
            @(negedge clk);
            chk($sformatf("vec%0d DMWE", i), 32'(bus.DMWE), 32'(tbl[i].dmwe));
            chk($sformatf("vec%0d BusErrM", i), 32'(bus.BusErrM), 32'(tbl[i].err));
            chk($sformatf("vec%0d StallM", i), 32'(bus.StallM), 0);
            chk($sformatf("vec%0d MemSel", i), 32'(bus.MemorySelectM), 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d DevReq", i), 32'({bus.DevReq1, bus.DevReq0}), 0);
        end
        // Slot-0 load, ack three cycles into the request.
        drive(1, 0, 2'b00, 32'h0000_7F04, 32'h0);
        bus.DevRD0 = 32'h1234_5678;
        sc = 0; rc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.StallM) break;
            sc++;
            @(posedge clk); #1;
            if (bus.DevReq0) rc++;
            bus.DevAck0 = bus.DevReq0 && rc == 3;
        end
        bus.DevAck0 = 0;
        chk("ld0 stall cycles", 32'(sc), 4);
        chk("ld0 CPURDM", bus.CPURDM, 32'h1234_5678);
        chk("ld0 MemSel DONE", 32'(bus.MemorySelectM), 1);
        chk("ld0 DevReq0 drop", 32'(bus.DevReq0), 0);
        chk("ld0 BusErrM", 32'(bus.BusErrM), 0);
        @(posedge clk); #1;
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        chk("ld0 idle MemSel", 32'(bus.MemorySelectM), 0);
        chk("ld0 idle StallM", 32'(bus.StallM), 0);
        // Slot-1 store with immediate ack.
        @(posedge clk); #1;
        drive(0, 1, 2'b00, 32'h0000_7F18, 32'hCAFE_0001);
        @(negedge clk);
        chk("st1 DMWE", 32'(bus.DMWE), 0);
        chk("st1 StallM idle", 32'(bus.StallM), 1);
        chk("st1 MemSel idle", 32'(bus.MemorySelectM), 1);
        @(posedge clk); #1;
        chk("st1 DevReq1", 32'(bus.DevReq1), 1);
        chk("st1 DevWE", 32'(bus.DevWE), 1);
        chk("st1 DevWD", bus.DevWD, 32'hCAFE_0001);
        chk("st1 DevAddr", 32'(bus.DevAddr), 32'h8);
        bus.DevAck1 = 1;
        @(posedge clk); #1;
        bus.DevAck1 = 0;
        chk("st1 DevReq1 drop", 32'(bus.DevReq1), 0);
        chk("st1 CPURDM kept", bus.CPURDM, 32'h1234_5678);
        chk("st1 StallM DONE", 32'(bus.StallM), 0);
        chk("st1 MemSel DONE", 32'(bus.MemorySelectM), 1);
        @(posedge clk); #1;
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        // Slot-1 load never acked; a stray slot-0 ack must be ignored.
        @(posedge clk); #1;
        drive(1, 0, 2'b00, 32'h0000_7F10, 32'h0);
        w = 0; pre_err = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.StallM) break;
            if (bus.DevReq1) w++;
            if (bus.BusErrM) pre_err++;
            bus.DevAck0 = (w == 5);
        end
        bus.DevAck0 = 0;
        chk("tmo wait cycles", 32'(w), 16);
        chk("tmo early BusErrM", 32'(pre_err), 0);
        chk("tmo BusErrM", 32'(bus.BusErrM), 1);
        chk("tmo CPURDM", bus.CPURDM, 0);
        chk("tmo MemSel DONE", 32'(bus.MemorySelectM), 1);
        @(posedge clk); #1;
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        chk("tmo BusErrM once", 32'(bus.BusErrM), 0);
        chk("tmo back idle", 32'(bus.MemorySelectM), 0);
        // Ack arriving on the final timeout cycle wins.
        @(posedge clk); #1;
        drive(1, 0, 2'b00, 32'h0000_7F08, 32'h0);
        bus.DevRD0 = 32'hAABB_CCDD;
        w = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.StallM) break;
            if (bus.DevReq0) w++;
            bus.DevAck0 = (w == 16);
        end
        bus.DevAck0 = 0;
        chk("race wait cycles", 32'(w), 16);
        chk("race BusErrM", 32'(bus.BusErrM), 0);
        chk("race CPURDM", bus.CPURDM, 32'hAABB_CCDD);
        @(posedge clk); #1;
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        // Interrupt synchroniser latency.
        @(posedge clk); #1;
        bus.DevIRQ0 = 1;
        @(posedge clk); #1;
        chk("irq0 1 edge", 32'(bus.HWInt), 0);
        @(posedge clk); #1;
        chk("irq0 2 edges", 32'(bus.HWInt), 32'h01);
        bus.DevIRQ1 = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("irq1 2 edges", 32'(bus.HWInt), 32'h03);
        // Asynchronous reset while waiting on a peripheral.
        drive(1, 0, 2'b00, 32'h0000_7F04, 32'h0);
        @(posedge clk); #1;
        chk("mrst DevReq0 pre", 32'(bus.DevReq0), 1);
        @(negedge clk);
        reset = 1;
        #1;
        chk("mrst DevReq0", 32'(bus.DevReq0), 0);
        chk("mrst StallM", 32'(bus.StallM), 0);
        chk("mrst MemSel", 32'(bus.MemorySelectM), 0);
        chk("mrst CPURDM", bus.CPURDM, 0);
        chk("mrst HWInt", 32'(bus.HWInt), 0);
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post rst StallM", 32'(bus.StallM), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
